// File: rtl/imem_loader_pkg.sv
// Shared constants, state encoding and frame layout for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned N_NODES = 16;
  localparam int unsigned SIZE    = 128;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned CNT_W   = ADDR_W + 1;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] BCAST_ID  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NODE   = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_CNT_HI = 3'd3,
    ST_DATA   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_CSUM   = 3'd6
  } state_e;

  // Byte order of a frame on the host link; payload is CNT*4 bytes, LSB first per word.
  typedef enum logic [2:0] {
    FLD_SYNC    = 3'd0,
    FLD_NODE    = 3'd1,
    FLD_CNT_LO  = 3'd2,
    FLD_CNT_HI  = 3'd3,
    FLD_PAYLOAD = 3'd4,
    FLD_CSUM    = 3'd5
  } frame_field_e;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream in, memory write bus and core hold controls out.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic [N_NODES-1:0]  wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [31:0]         wr_data;
  logic [N_NODES-1:0]  core_hold;
  logic                busy;
  logic                err;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, core_hold, busy, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, core_hold, busy, err
  );
endinterface

// File: rtl/imem_loader_word_asm.sv
// Little-endian byte-to-word assembler with lane index and running XOR checksum.
module imem_loader_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [7:0]  o_xor,
  output logic        o_word_done_c
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic [7:0]  r_xor;

  // The word itself is not cleared at frame start so the write bus keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
      r_xor  <= 8'd0;
    end else if (i_clr) begin
      r_idx <= 2'd0;
      r_xor <= 8'd0;
    end else if (i_en) begin
      r_word[{r_idx, 3'b000} +: 8] <= i_byte;
      r_xor                        <= r_xor ^ i_byte;
      r_idx                        <= r_idx + 2'd1;
    end
  end

  assign o_word        = r_word;
  assign o_xor         = r_xor;
  assign o_word_done_c = i_en && (r_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Frame parser that programs per-node instruction memories and holds cores in reset meanwhile.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  io
);

  state_e              r_state;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_err;
  logic [N_NODES-1:0]  r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [N_NODES-1:0]  r_core_hold;
  logic [N_NODES-1:0]  r_mask;
  logic [N_NODES-1:0]  r_new_hold;
  logic [7:0]          r_cnt_lo;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_word_cnt;

  logic                w_accept;
  logic                w_node_ok;
  logic [N_NODES-1:0]  w_sel_mask;
  logic [15:0]         w_count;
  logic                w_count_bad;
  logic                w_asm_clr;
  logic                w_asm_en;
  logic [31:0]         w_word;
  logic [7:0]          w_xor;
  logic                w_word_done;

  assign w_accept    = io.in_valid && r_in_ready;
  assign w_node_ok   = (32'(io.in_data) < N_NODES) || (io.in_data == BCAST_ID);
  assign w_sel_mask  = (io.in_data == BCAST_ID) ? '1 : (N_NODES'(1) << io.in_data);
  assign w_count     = {io.in_data, r_cnt_lo};
  assign w_count_bad = (w_count == 16'd0) || (w_count > 16'(SIZE));
  assign w_asm_clr   = w_accept && (r_state == ST_CNT_HI);
  assign w_asm_en    = w_accept && (r_state == ST_DATA);

  imem_loader_word_asm u_word_asm (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (w_asm_clr),
    .i_en          (w_asm_en),
    .i_byte        (io.in_data),
    .o_word        (w_word),
    .o_xor         (w_xor),
    .o_word_done_c (w_word_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_wr_en     <= '0;
      r_wr_addr   <= '0;
      r_core_hold <= '0;
      r_mask      <= '0;
      r_new_hold  <= '0;
      r_cnt_lo    <= 8'd0;
      r_count     <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_wr_en <= '0;
      case (r_state)
        ST_IDLE: if (w_accept && io.in_data == SYNC_BYTE) begin
          r_state <= ST_NODE;
          r_busy  <= 1'b1;
          r_err   <= 1'b0;
        end
        ST_NODE: if (w_accept) begin
          if (w_node_ok) begin
            r_mask      <= w_sel_mask;
            r_new_hold  <= w_sel_mask & ~r_core_hold;
            r_core_hold <= r_core_hold | w_sel_mask;
            r_state     <= ST_CNT_LO;
          end else begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_CNT_LO: if (w_accept) begin
          r_cnt_lo <= io.in_data;
          r_state  <= ST_CNT_HI;
        end
        // Only holds raised by this frame are dropped; earlier bad-checksum holds persist.
        ST_CNT_HI: if (w_accept) begin
          if (w_count_bad) begin
            r_err       <= 1'b1;
            r_core_hold <= r_core_hold & ~r_new_hold;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_count    <= CNT_W'(w_count);
            r_word_cnt <= '0;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: if (w_word_done) begin
          r_wr_en    <= r_mask;
          r_wr_addr  <= r_word_cnt[ADDR_W-1:0];
          r_in_ready <= 1'b0;
          r_state    <= ST_WRITE;
        end
        ST_WRITE: begin
          r_in_ready <= 1'b1;
          r_word_cnt <= r_word_cnt + CNT_W'(1);
          r_state    <= (r_word_cnt + CNT_W'(1) == r_count) ? ST_CSUM : ST_DATA;
        end
        ST_CSUM: if (w_accept) begin
          if (io.in_data == w_xor) r_core_hold <= r_core_hold & ~r_mask;
          else                     r_err       <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign io.in_ready  = r_in_ready;
  assign io.wr_en     = r_wr_en;
  assign io.wr_addr   = r_wr_addr;
  assign io.wr_data   = w_word;
  assign io.core_hold = r_core_hold;
  assign io.busy      = r_busy;
  assign io.err       = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: framing, broadcast, checksum, errors, full image, reset.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  logic [N_NODES-1:0] q_en[$];
  logic [ADDR_W-1:0]  q_addr[$];
  logic [31:0]        q_data[$];
  int                 n_ready_lo = 0;
  int                 n_ready_bad = 0;

  imem_loader_if bus();

  imem_loader dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  // Record every write strobe and any in_ready drop that is not a WRITE cycle.
  always @(negedge clk) begin
    if (bus.wr_en != '0) begin
      q_en.push_back(bus.wr_en);
      q_addr.push_back(bus.wr_addr);
      q_data.push_back(bus.wr_data);
    end
    if (bus.in_ready === 1'b0) begin
      n_ready_lo++;
      if (bus.wr_en == '0) n_ready_bad++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    q_en.delete(); q_addr.delete(); q_data.delete();
    n_ready_lo = 0; n_ready_bad = 0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap = 0);
    int n;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready stuck low, byte %02h", b);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n = 1);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b exp 1", bus.in_ready); end
    checks++; if (bus.wr_en !== 16'h0000) begin failures++; $display("FAIL rst_wr_en: got %h exp 0000", bus.wr_en); end
    checks++; if (bus.wr_addr !== 7'd0) begin failures++; $display("FAIL rst_wr_addr: got %h exp 0", bus.wr_addr); end
    checks++; if (bus.wr_data !== 32'd0) begin failures++; $display("FAIL rst_wr_data: got %h exp 0", bus.wr_data); end
    checks++; if (bus.core_hold !== 16'h0000) begin failures++; $display("FAIL rst_core_hold: got %h exp 0000", bus.core_hold); end
    checks++; if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin failures++; $display("FAIL rst_busy_err: got %b%b exp 00", bus.busy, bus.err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    clear_mon();
    send_byte(8'hA5);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL sw_busy: got %b exp 1", bus.busy); end
    send_byte(8'h03);
    checks++; if (bus.core_hold !== 16'h0008) begin failures++; $display("FAIL sw_hold_set: got %h exp 0008", bus.core_hold); end
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h02); send_byte(8'h50);
    checks++; if (bus.wr_en !== 16'h0000) begin failures++; $display("FAIL sw_early_wr: got %h exp 0000", bus.wr_en); end
    send_byte(8'h00);
    checks++; if (bus.wr_en !== 16'h0008 || bus.wr_addr !== 7'd0 || bus.wr_data !== 32'h00500293)
      begin failures++; $display("FAIL sw_write: got en=%h a=%h d=%h exp 0008/0/00500293", bus.wr_en, bus.wr_addr, bus.wr_data); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL sw_ready_write: got %b exp 0", bus.in_ready); end
    checks++; if (bus.core_hold !== 16'h0008) begin failures++; $display("FAIL sw_hold_mid: got %h exp 0008", bus.core_hold); end
    send_byte(8'hC1);
    checks++; if (bus.core_hold !== 16'h0000 || bus.err !== 1'b0 || bus.busy !== 1'b0)
      begin failures++; $display("FAIL sw_end: got hold=%h err=%b busy=%b exp 0000/0/0", bus.core_hold, bus.err, bus.busy); end
    idle(2);
    checks++; if (q_en.size() != 1) begin failures++; $display("FAIL sw_nwrites: got %0d exp 1", q_en.size()); end
  endtask

  task automatic test_broadcast();
    logic [7:0] s[$] = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'hFF);
    checks++; if (bus.core_hold !== 16'hFFFF) begin failures++; $display("FAIL bc_hold_set: got %h exp FFFF", bus.core_hold); end
    foreach (s[i]) send_byte(s[i]);
    checks++; if (bus.core_hold !== 16'h0000 || bus.err !== 1'b0) begin failures++; $display("FAIL bc_end: got hold=%h err=%b exp 0000/0", bus.core_hold, bus.err); end
    idle(2);
    checks++;
    if (q_en.size() != 2) begin failures++; $display("FAIL bc_nwrites: got %0d exp 2", q_en.size()); end
    else if (q_en[0] !== 16'hFFFF || q_addr[0] !== 7'd0 || q_data[0] !== 32'h44332211 ||
             q_en[1] !== 16'hFFFF || q_addr[1] !== 7'd1 || q_data[1] !== 32'h88776655) begin
      failures++;
      $display("FAIL bc_writes: got %h/%h/%h %h/%h/%h exp FFFF/0/44332211 FFFF/1/88776655",
               q_en[0], q_addr[0], q_data[0], q_en[1], q_addr[1], q_data[1]);
    end
    checks++; if (n_ready_lo != 2 || n_ready_bad != 0) begin failures++; $display("FAIL bc_ready: got lo=%0d bad=%0d exp 2/0", n_ready_lo, n_ready_bad); end
  endtask

  task automatic test_csum_mismatch();
    logic [7:0] a[$] = '{8'hA5, 8'h05, 8'h01, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00, 8'h00};
    logic [7:0] b[$] = '{8'h05, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    clear_mon();
    foreach (a[i]) send_byte(a[i]);
    checks++; if (bus.err !== 1'b1 || bus.core_hold !== 16'h0020 || bus.busy !== 1'b0)
      begin failures++; $display("FAIL cm_bad: got err=%b hold=%h busy=%b exp 1/0020/0", bus.err, bus.core_hold, bus.busy); end
    checks++; if (q_en.size() != 1 || q_en[0] !== 16'h0020 || q_data[0] !== 32'h00500293)
      begin failures++; $display("FAIL cm_write: got n=%0d exp one write en=0020 d=00500293", q_en.size()); end
    send_byte(8'hA5);
    checks++; if (bus.err !== 1'b0 || bus.core_hold !== 16'h0020) begin failures++; $display("FAIL cm_sync_clear: got err=%b hold=%h exp 0/0020", bus.err, bus.core_hold); end
    foreach (b[i]) send_byte(b[i]);
    checks++; if (bus.err !== 1'b0 || bus.core_hold !== 16'h0000) begin failures++; $display("FAIL cm_recover: got err=%b hold=%h exp 0/0000", bus.err, bus.core_hold); end
    idle(2);
  endtask

  task automatic test_bad_fields();
    clear_mon();
    send_byte(8'hA5); send_byte(8'h20);
    checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.core_hold !== 16'h0000)
      begin failures++; $display("FAIL bf_node: got err=%b busy=%b hold=%h exp 1/0/0000", bus.err, bus.busy, bus.core_hold); end
    send_byte(8'hA5);
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL bf_sync_clear: got %b exp 0", bus.err); end
    send_byte(8'h07);
    checks++; if (bus.core_hold !== 16'h0080) begin failures++; $display("FAIL bf_hold_set: got %h exp 0080", bus.core_hold); end
    send_byte(8'h81); send_byte(8'h00);
    checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.core_hold !== 16'h0000)
      begin failures++; $display("FAIL bf_cnt129: got err=%b busy=%b hold=%h exp 1/0/0000", bus.err, bus.busy, bus.core_hold); end
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h00);
    checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.core_hold !== 16'h0000)
      begin failures++; $display("FAIL bf_cnt0: got err=%b busy=%b hold=%h exp 1/0/0000", bus.err, bus.busy, bus.core_hold); end
    send_byte(8'hA5);
    checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL bf_resync: got err=%b busy=%b exp 0/1", bus.err, bus.busy); end
    send_byte(8'h40);
    idle(2);
    checks++; if (q_en.size() != 0) begin failures++; $display("FAIL bf_nowrite: got %0d writes exp 0", q_en.size()); end
  endtask

  task automatic test_full_image();
    logic [31:0] exp;
    int bad;
    clear_mon();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h80); send_byte(8'h00);
    for (int i = 0; i < 128; i++) begin
      send_byte(8'(i)); send_byte(8'h5A); send_byte(8'hC3); send_byte(8'(i) ^ 8'hFF);
    end
    send_byte(8'h00);
    checks++; if (bus.core_hold !== 16'h0000 || bus.err !== 1'b0 || bus.busy !== 1'b0)
      begin failures++; $display("FAIL fi_end: got hold=%h err=%b busy=%b exp 0000/0/0", bus.core_hold, bus.err, bus.busy); end
    idle(2);
    checks++; if (q_en.size() != 128) begin failures++; $display("FAIL fi_nwrites: got %0d exp 128", q_en.size()); end
    bad = 0;
    for (int i = 0; i < 128 && i < q_en.size(); i++) begin
      exp = {8'(i) ^ 8'hFF, 8'hC3, 8'h5A, 8'(i)};
      if (q_en[i] !== 16'h0001 || q_addr[i] !== 7'(i) || q_data[i] !== exp) begin
        if (bad < 4) $display("FAIL fi_word%0d: got en=%h a=%h d=%h exp 0001/%h/%h", i, q_en[i], q_addr[i], q_data[i], 7'(i), exp);
        bad++;
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL fi_words: %0d bad words exp 0", bad); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] g[$] = '{8'hA5, 8'h09, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    clear_mon();
    send_byte(8'hA5, 1); send_byte(8'h09, 2); send_byte(8'h01); send_byte(8'h00, 1);
    send_byte(8'hAA, 2); send_byte(8'hBB, 1);
    checks++; if (bus.core_hold !== 16'h0200 || bus.busy !== 1'b1) begin failures++; $display("FAIL rm_pre: got hold=%h busy=%b exp 0200/1", bus.core_hold, bus.busy); end
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.core_hold !== 16'h0000 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.in_ready !== 1'b1 ||
                  bus.wr_en !== 16'h0000 || bus.wr_addr !== 7'd0 || bus.wr_data !== 32'd0)
      begin failures++; $display("FAIL rm_async: got hold=%h busy=%b err=%b rdy=%b en=%h a=%h d=%h exp reset values",
                                  bus.core_hold, bus.busy, bus.err, bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h00, 1); send_byte(8'hFF, 2);
    idle(2);
    checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.core_hold !== 16'h0000)
      begin failures++; $display("FAIL rm_noise: got err=%b busy=%b hold=%h exp 0/0/0000", bus.err, bus.busy, bus.core_hold); end
    foreach (g[i]) send_byte(g[i], i % 2);
    idle(2);
    checks++; if (q_en.size() != 1 || q_en[0] !== 16'h0200 || q_data[0] !== 32'h12345678 ||
                  bus.core_hold !== 16'h0000 || bus.err !== 1'b0)
      begin failures++; $display("FAIL rm_after: got n=%0d hold=%h err=%b exp 1 write 0200/12345678, 0000/0",
                                  q_en.size(), bus.core_hold, bus.err); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_broadcast();
    test_csum_mismatch();
    test_bad_fields();
    test_full_image();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
